// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register sequencer.
// SPIREG_STATUS_EN selects whether address 4'hF is a read-only status register.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WRITE,
    READ,
    ERROR
  } state_e;

  localparam int CMD_W       = 7;
  localparam int CMD_RSV_HI  = 6;
  localparam int CMD_RSV_LO  = 4;
  localparam int CMD_ADDR_HI = 3;
  localparam int CMD_ADDR_LO = 0;

  localparam logic [3:0] STATUS_ADDR = 4'hF;

  // Auto-increment: 0..last, then (with the status register) 4'hF, then back to 0.
  function automatic logic [3:0] ptr_next(input logic [3:0] ptr, input logic [3:0] last);
`ifdef SPIREG_STATUS_EN
    if (ptr == last) return STATUS_ADDR;
    if (ptr == STATUS_ADDR) return 4'h0;
    return ptr + 4'h1;
`else
    return (ptr == last) ? 4'h0 : ptr + 4'h1;
`endif
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level, followed by an edge
// register that yields single-cycle rise/fall pulses in the clk domain.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // NOTE: flop chains use non-blocking assignments so each stage samples the
  // previous stage's old value; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// Command sequencer and auto-incrementing register bank behind the SPI slave.
// Define SPIREG_STATUS_EN to expose iStatus as read-only register 4'hF.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int         NREGS    = 8,
  parameter logic [7:0] MAGIC    = 8'hA5,
  parameter logic [7:0] ERR_BYTE = 8'hFF
) (
  input  logic                 sysclk,
  input  logic                 rst_n,
  input  logic                 iRxReady,
  input  logic [7:0]           iRx,
  input  logic                 iSPICS,
  input  logic [7:0]           iStatus,
  output logic                 oTxReady,
  output logic [7:0]           oTx,
  output logic [8*NREGS-1:0]   oRegs,
  output logic                 oRegWr,
  output logic [3:0]           oRegAddr,
  output logic                 oErr
);

  localparam logic [3:0] LAST_ADDR = 4'(NREGS - 1);

  state_e     state_q, state_d;
  logic [3:0] ptr_q, ptr_d;
  logic [7:0] regs_q [NREGS];

  logic       tx_ready_q, tx_ready_d;
  logic [7:0] tx_q, tx_d;
  logic       reg_wr_q, reg_wr_d;
  logic [3:0] reg_addr_q, reg_addr_d;
  logic       err_q, err_d;

  logic       byte_evt, frame_start, frame_end;
  logic       rdy_fall_unused;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [3:0] cmd_addr, ptr_inc, rd_addr;
  logic [7:0] rd_data;
  logic       addr_ok, cmd_ok;

  sync_edge u_sync_rdy (
    .clk    (sysclk),
    .rst_n  (rst_n),
    .async_i(iRxReady),
    .rise_o (byte_evt),
    .fall_o (rdy_fall_unused)
  );

  // CS synchroniser resets low, so CS held low across reset never looks like a frame start.
  sync_edge u_sync_cs (
    .clk    (sysclk),
    .rst_n  (rst_n),
    .async_i(iSPICS),
    .rise_o (frame_end),
    .fall_o (frame_start)
  );

  assign cmd_addr = iRx[CMD_ADDR_HI:CMD_ADDR_LO];
  assign ptr_inc  = ptr_next(ptr_q, LAST_ADDR);
  assign rd_addr  = (state_q == CMD) ? cmd_addr : ptr_inc;

`ifdef SPIREG_STATUS_EN
  assign addr_ok = (cmd_addr <= LAST_ADDR) || (cmd_addr == STATUS_ADDR);
`else
  logic status_unused;
  assign status_unused = ^iStatus;
  assign addr_ok = (cmd_addr <= LAST_ADDR);
`endif
  assign cmd_ok = addr_ok && (iRx[CMD_RSV_HI:CMD_RSV_LO] == 3'b000);

  // Read mux: the byte is sampled into tx_q when presented, so later writes do not alter it.
  always_comb begin
    rd_data = ERR_BYTE;
    for (int k = 0; k < NREGS; k++) begin
      if (rd_addr == 4'(k)) rd_data = regs_q[k];
    end
`ifdef SPIREG_STATUS_EN
    if (rd_addr == STATUS_ADDR) rd_data = iStatus;
`endif
  end

  // NOTE: every variable driven here gets a default first; a path that skips
  // an assignment would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    tx_ready_d = 1'b0;
    tx_d       = tx_q;
    reg_wr_d   = 1'b0;
    reg_addr_d = reg_addr_q;
    err_d      = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = ptr_q;

    if (frame_end) begin
      // Frame end outranks a coincident byte event; that byte is dropped.
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (frame_start) begin
            tx_ready_d = 1'b1;
            tx_d       = MAGIC;
            state_d    = CMD;
          end
        end
        CMD: begin
          if (byte_evt) begin
            tx_ready_d = 1'b1;
            if (!cmd_ok) begin
              err_d   = 1'b1;
              tx_d    = ERR_BYTE;
              state_d = ERROR;
            end else begin
              ptr_d   = cmd_addr;
              tx_d    = rd_data;
              state_d = iRx[CMD_W] ? WRITE : READ;
            end
          end
        end
        WRITE: begin
          if (byte_evt) begin
            ptr_d = ptr_inc;
            // The status address accepts the byte but changes nothing.
            if (ptr_q <= LAST_ADDR) begin
              wr_en      = 1'b1;
              reg_wr_d   = 1'b1;
              reg_addr_d = ptr_q;
            end
          end
        end
        READ: begin
          if (byte_evt) begin
            ptr_d      = ptr_inc;
            tx_ready_d = 1'b1;
            tx_d       = rd_data;
          end
        end
        ERROR: begin
          if (byte_evt) begin
            tx_ready_d = 1'b1;
            tx_d       = ERR_BYTE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 4'h0;
      tx_ready_q <= 1'b0;
      tx_q       <= 8'h00;
      reg_wr_q   <= 1'b0;
      reg_addr_q <= 4'h0;
      err_q      <= 1'b0;
      // NOTE: the bank is tiny and drives live fan configuration, so it is
      // built from resettable flops rather than an unreset memory.
      for (int k = 0; k < NREGS; k++) regs_q[k] <= 8'h00;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      tx_ready_q <= tx_ready_d;
      tx_q       <= tx_d;
      reg_wr_q   <= reg_wr_d;
      reg_addr_q <= reg_addr_d;
      err_q      <= err_d;
      for (int k = 0; k < NREGS; k++) begin
        if (wr_en && (wr_addr == 4'(k))) regs_q[k] <= iRx;
      end
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign oRegs[8*g +: 8] = regs_q[g];
  end

  assign oTxReady = tx_ready_q;
  assign oTx      = tx_q;
  assign oRegWr   = reg_wr_q;
  assign oRegAddr = reg_addr_q;
  assign oErr     = err_q;

endmodule
